pong_match_ctrl: RTL and testbench
==================================

Name: pong_match_ctrl

Overview:
- Match/rally sequencer that sits directly downstream of the ball collision logic.
- Consumes the per-edge miss indications and owns both players' scores; feeds score values to the seven-segment decoders.
- Drives a ball-hold/serve interface back to the ball-motion logic: a timed serve delay after every point, win detection and a game-over hold.
- Restart switch starts a new match.

Parameters:
WIN_SCORE, 7, points needed to win a match (1..15)
SERVE_TICKS, 120, tick pulses the ball is held at centre before each serve (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
tick  input  1  one-cycle game-rate enable (ball-motion rate); paces only the serve timer
miss_left  input  1  level; ball beyond left edge (P2 scores)
miss_right  input  1  level; ball beyond right edge (P1 scores)
restart  input  1  level switch; rising edge starts a new match
score_p1  output  4  P1 score, binary
score_p2  output  4  P2 score, binary
ball_hold  output  1  1 = ball held/re-centred, 0 = ball free to move
serve_dir  output  1  direction of next/current serve: 0 = toward left, 1 = toward right
point_pulse  output  1  one-cycle strobe when a point is awarded (sound-effect hook)
game_over  output  1  1 while a match is decided
winner  output  2  00 none, 01 P1, 10 P2

Behaviour:
- Reset (rst_n=0 at clk edge):
  - scores 0; serve_dir 0; winner 00; game_over 0; point_pulse 0.
  - ball_hold 1; serve counter 0; restart_q 0; state SERVE_WAIT.
- All outputs are registered.
- States: SERVE_WAIT, PLAY, POINT, OVER.
- SERVE_WAIT:
  - ball_hold=1.
  - Counter increments only on tick.
  - On the tick where counter==SERVE_TICKS-1: counter clears, state goes to PLAY, ball_hold drops at that edge. Hold therefore spans exactly SERVE_TICKS tick pulses.
  - Misses are ignored.
- PLAY:
  - ball_hold=0. Misses are sampled every clk, independent of tick.
  - miss_right only: score_p1+1, serve_dir<=1.
  - miss_left only: score_p2+1, serve_dir<=0.
  - Either single miss: point_pulse<=1, ball_hold<=1, state POINT, all on the same edge.
  - Both misses in the same cycle: no score, no pulse; ball_hold<=1, state SERVE_WAIT (replay).
- POINT (exactly one cycle):
  - point_pulse returns 0.
  - If a score equals WIN_SCORE: state OVER, game_over<=1, winner set.
  - Otherwise: state SERVE_WAIT with counter 0.
- OVER: ball_hold=1, scores frozen, misses and tick ignored; leaves only via restart edge or reset.
- Restart:
  - Rising edge = restart & ~restart_q, with restart_q registered every clk.
  - Valid in any state; highest priority below reset.
  - Effect: scores 0, winner 00, game_over 0, serve_dir 0, counter 0, ball_hold 1, state SERVE_WAIT.
  - A miss in the same cycle is discarded.
  - Restart held high causes no repeated action.
- Score arithmetic:
  - 4-bit unsigned.
  - A score can never exceed WIN_SCORE, because scoring stops in OVER, so no wrap.
- Miss inputs remain asserted for many cycles because upstream holds the ball. Only the first sampled cycle in PLAY counts; later cycles fall in POINT/SERVE_WAIT and are ignored.
- Reset asserted mid-serve or mid-POINT overrides everything; no partial score update survives.

Decomposition:
- Shared package pong_pkg:
  - state enum (SERVE_WAIT, PLAY, POINT, OVER).
  - winner encodings (WIN_NONE, WIN_P1, WIN_P2).
  - serve_dir encodings (DIR_LEFT, DIR_RIGHT).
  - score width constant (4).
- One sub-module, pong_serve_timer: tick-gated counter with clear input and done pulse, parameterised by SERVE_TICKS; width $clog2(SERVE_TICKS+1).
- Restart edge detect stays inline.

Test Plan:
- Reset, SERVE_TICKS=4, tick every 3 clk -> ball_hold=1 through 4 ticks, falls on the edge of the 4th tick; scores 0/0, winner 00.
- PLAY, miss_right held 20 clk -> score_p1 0→1 exactly once, point_pulse high exactly 1 cycle, ball_hold=1 on the same edge, serve_dir=1, back to PLAY after 4 more ticks.
- WIN_SCORE=3, three miss_left events in PLAY -> score_p2=3, one cycle later game_over=1 and winner=10; further misses and ticks leave all outputs unchanged.
- miss_left and miss_right asserted in the same PLAY cycle -> scores unchanged, point_pulse stays 0, ball_hold=1, serve wait restarts.
- In OVER (P1 won 3-1), raise restart and hold it -> one cycle later scores 0/0, game_over=0, winner=00, serve_dir=0, ball_hold=1; no second clear while held.
- rst_n low for 1 clk mid-SERVE_WAIT with scores 2/1 -> all reset values next cycle; counter restarts from 0 (full SERVE_TICKS hold).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller.
// Contents: match state enum, winner and serve-direction encodings,
// score width, and a small win-test helper.
package pong_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        POINT      = 2'd2,
        OVER       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // True when a score has reached the match-winning value.
    function automatic logic reached_win(input logic [SCORE_W-1:0] score,
                                         input logic [SCORE_W-1:0] win);
        return (score == win);
    endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Serve delay timer: counts tick pulses while enabled and pulses done on the
// tick that completes SERVE_TICKS pulses, wrapping back to zero.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   en     - counting allowed (ball held waiting to serve)
//   clear  - force count to zero; overrides counting and suppresses done
//   tick   - game-rate enable pulse
//   done   - combinational strobe on the final tick of the serve delay
module pong_serve_timer #(
    parameter int SERVE_TICKS = 120
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int              CNT_W = $clog2(SERVE_TICKS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             done_s;

    // Next count and done strobe; clear wins over an incoming tick.
    always_comb begin
        count_s = count_r;
        done_s  = 1'b0;
        if (clear) begin
            count_s = ZERO;
        end else if (en && tick) begin
            if (count_r == LAST) begin
                count_s = ZERO;
                done_s  = 1'b1;
            end else begin
                count_s = count_r + ONE;
            end
        end else begin
            count_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else begin
            count_r <= count_s;
        end
    end

    assign done = done_s;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match/rally sequencer. Turns edge-miss levels into score updates,
// holds the ball for a timed serve after each point, detects the winner and
// freezes the match until a restart edge.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   tick                   - game-rate enable, paces the serve delay only
//   miss_left, miss_right  - ball beyond left (P2 scores) / right (P1 scores)
//   restart                - level switch, rising edge starts a new match
//   score_p1, score_p2     - binary scores
//   ball_hold              - 1 holds the ball at centre
//   serve_dir              - 0 serve toward left, 1 toward right
//   point_pulse            - one-cycle strobe when a point is awarded
//   game_over, winner      - match decided flag and winner (00/01/10)
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               miss_left,
    input  logic               miss_right,
    input  logic               restart,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               ball_hold,
    output logic               serve_dir,
    output logic               point_pulse,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] S_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] S_ZERO = SCORE_W'(0);

    state_t             state_r,    state_s;
    logic [SCORE_W-1:0] score_p1_r, score_p1_s;
    logic [SCORE_W-1:0] score_p2_r, score_p2_s;
    logic               hold_r,     hold_s;
    logic               dir_r,      dir_s;
    logic               pulse_r,    pulse_s;
    logic               over_r,     over_s;
    winner_t            winner_r,   winner_s;
    logic               restart_q_r;
    logic               restart_edge_s;
    logic               serve_done_s;
    logic               timer_en_s;
    logic               timer_clear_s;

    assign restart_edge_s = restart & ~restart_q_r;

    // The timer only runs while waiting to serve; anywhere else it is held at
    // zero so every serve wait starts from a fresh count.
    assign timer_en_s    = (state_r == SERVE_WAIT);
    assign timer_clear_s = restart_edge_s | (state_r != SERVE_WAIT);

    pong_serve_timer #(
        .SERVE_TICKS(SERVE_TICKS)
    ) u_serve_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timer_en_s),
        .clear (timer_clear_s),
        .tick  (tick),
        .done  (serve_done_s)
    );

    // Next-state and next-output logic; a restart edge overrides every state.
    always_comb begin
        state_s    = state_r;
        score_p1_s = score_p1_r;
        score_p2_s = score_p2_r;
        hold_s     = hold_r;
        dir_s      = dir_r;
        pulse_s    = 1'b0;
        over_s     = over_r;
        winner_s   = winner_r;

        if (restart_edge_s) begin
            state_s    = SERVE_WAIT;
            score_p1_s = S_ZERO;
            score_p2_s = S_ZERO;
            hold_s     = 1'b1;
            dir_s      = DIR_LEFT;
            over_s     = 1'b0;
            winner_s   = WIN_NONE;
        end else begin
            case (state_r)
                SERVE_WAIT: begin
                    hold_s = 1'b1;
                    if (serve_done_s) begin
                        state_s = PLAY;
                        hold_s  = 1'b0;
                    end else begin
                        state_s = SERVE_WAIT;
                    end
                end
                PLAY: begin
                    hold_s = 1'b0;
                    if (miss_left && miss_right) begin
                        // Ambiguous double miss: replay the serve, nobody scores.
                        state_s = SERVE_WAIT;
                        hold_s  = 1'b1;
                    end else if (miss_right) begin
                        state_s    = POINT;
                        score_p1_s = score_p1_r + S_ONE;
                        dir_s      = DIR_RIGHT;
                        pulse_s    = 1'b1;
                        hold_s     = 1'b1;
                    end else if (miss_left) begin
                        state_s    = POINT;
                        score_p2_s = score_p2_r + S_ONE;
                        dir_s      = DIR_LEFT;
                        pulse_s    = 1'b1;
                        hold_s     = 1'b1;
                    end else begin
                        state_s = PLAY;
                    end
                end
                POINT: begin
                    hold_s = 1'b1;
                    if (reached_win(score_p1_r, WIN_S)) begin
                        state_s  = OVER;
                        over_s   = 1'b1;
                        winner_s = WIN_P1;
                    end else if (reached_win(score_p2_r, WIN_S)) begin
                        state_s  = OVER;
                        over_s   = 1'b1;
                        winner_s = WIN_P2;
                    end else begin
                        state_s = SERVE_WAIT;
                    end
                end
                OVER: begin
                    hold_s  = 1'b1;
                    state_s = OVER;
                end
                default: begin
                    state_s = SERVE_WAIT;
                    hold_s  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= SERVE_WAIT;
            score_p1_r  <= S_ZERO;
            score_p2_r  <= S_ZERO;
            hold_r      <= 1'b1;
            dir_r       <= DIR_LEFT;
            pulse_r     <= 1'b0;
            over_r      <= 1'b0;
            winner_r    <= WIN_NONE;
            restart_q_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            score_p1_r  <= score_p1_s;
            score_p2_r  <= score_p2_s;
            hold_r      <= hold_s;
            dir_r       <= dir_s;
            pulse_r     <= pulse_s;
            over_r      <= over_s;
            winner_r    <= winner_s;
            restart_q_r <= restart;
        end
    end

    assign score_p1    = score_p1_r;
    assign score_p2    = score_p2_r;
    assign ball_hold   = hold_r;
    assign serve_dir   = dir_r;
    assign point_pulse = pulse_r;
    assign game_over   = over_r;
    assign winner      = winner_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with a small match model.
module tb_pong_match_ctrl;

    localparam int WIN = 3;
    localparam int ST  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       ball_hold;
    logic       serve_dir;
    logic       point_pulse;
    logic       game_over;
    logic [1:0] winner;

    pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .miss_left(miss_left), .miss_right(miss_right), .restart(restart),
        .score_p1(score_p1), .score_p2(score_p2), .ball_hold(ball_hold),
        .serve_dir(serve_dir), .point_pulse(point_pulse),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick_mode = 0;   // 0: every 3rd clk, 1: random, 2: none

    // Model of the match: scores, who served, and where the rally stands.
    int m_p1, m_p2, m_win, m_ticks;
    bit m_dir, m_over, m_hold, m_pulse, m_judge, m_rq;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit ml, input bit mr, input bit rs);
        bit rise;
        if (!r) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_ticks = 0;
            m_dir = 0; m_over = 0; m_hold = 1; m_pulse = 0; m_judge = 0; m_rq = 0;
        end else begin
            rise = rs && !m_rq;
            m_rq = rs;
            m_pulse = 0;
            if (rise) begin
                m_p1 = 0; m_p2 = 0; m_win = 0; m_over = 0; m_dir = 0;
                m_ticks = 0; m_hold = 1; m_judge = 0;
            end else if (m_over) begin
                m_hold = 1;
            end else if (m_judge) begin
                m_judge = 0;
                m_ticks = 0;
                if (m_p1 == WIN) begin m_over = 1; m_win = 1; end
                else if (m_p2 == WIN) begin m_over = 1; m_win = 2; end
            end else if (m_hold) begin
                if (t) begin
                    m_ticks++;
                    if (m_ticks == ST) begin m_ticks = 0; m_hold = 0; end
                end
            end else begin
                if (ml && mr) begin
                    m_hold = 1; m_ticks = 0;
                end else if (mr) begin
                    m_p1++; m_dir = 1; m_pulse = 1; m_hold = 1; m_judge = 1;
                end else if (ml) begin
                    m_p2++; m_dir = 0; m_pulse = 1; m_hold = 1; m_judge = 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input bit r, input bit ml, input bit mr, input bit rs);
        bit t;
        if (tick_mode == 0)      t = ((cyc % 3) == 2);
        else if (tick_mode == 1) t = ($urandom_range(0, 3) == 0);
        else                     t = 1'b0;
        cyc++;
        rst_n = r; tick = t; miss_left = ml; miss_right = mr; restart = rs;
        @(posedge clk);
        model_step(r, t, ml, mr, rs);
        #1;
        chk("score_p1",    int'(score_p1),    m_p1);
        chk("score_p2",    int'(score_p2),    m_p2);
        chk("ball_hold",   int'(ball_hold),   int'(m_hold));
        chk("serve_dir",   int'(serve_dir),   int'(m_dir));
        chk("point_pulse", int'(point_pulse), int'(m_pulse));
        chk("game_over",   int'(game_over),   int'(m_over));
        chk("winner",      int'(winner),      m_win);
    endtask

    task automatic wait_play();
        int n = 0;
        while ((m_hold || m_judge || m_over) && n < 200) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("wait_play_bound", (n < 200) ? 1 : 0, 1);
    endtask

    task automatic miss(input bit l, input bit r, input int n);
        for (int i = 0; i < n; i++) step(1'b1, l, r, 1'b0);
    endtask

    task automatic do_restart();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic count_serve(input string name);
        int nt = 0;
        int n = 0;
        while (ball_hold && n < 60) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (tick) nt++;
            n++;
        end
        chk(name, nt, ST);
    endtask

    initial begin
        int pulses;
        int hold_len;
        bit pl, pr;
        // Reset
        tick_mode = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_hold", int'(ball_hold), 1);
        chk("rst_scores", int'(score_p1) + int'(score_p2), 0);
        chk("rst_winner", int'(winner), 0);

        // Serve hold spans exactly 4 ticks (tick on every 3rd clk -> 12 clk)
        cyc = 0;
        begin
            int nt = 0;
            int n = 0;
            while (ball_hold && n < 60) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                if (tick) nt++;
                n++;
            end
            chk("first_serve_ticks", nt, 4);
            chk("first_serve_clks", n, 12);
        end

        // miss_right held 20 clk scores once
        tick_mode = 2;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            pulses += int'(point_pulse);
        end
        chk("held_miss_pulses", pulses, 1);
        chk("held_miss_p1", int'(score_p1), 1);
        chk("held_miss_dir", int'(serve_dir), 1);
        tick_mode = 0;
        count_serve("reserve_ticks");

        // Randomized play
        tick_mode = 1;
        hold_len = 0; pl = 0; pr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_len == 0) begin
                int p;
                p = $urandom_range(0, 19);
                pl = (p >= 10 && p < 15) || p == 19;
                pr = (p >= 15);
                hold_len = $urandom_range(1, 6);
            end
            hold_len--;
            step(($urandom_range(0, 499) != 0), pl, pr, ($urandom_range(0, 149) == 0));
        end

        // P2 wins 0-3
        do_restart();
        for (int k = 0; k < 3; k++) begin
            wait_play();
            miss(1'b1, 1'b0, 3);
        end
        chk("p2_win_score", int'(score_p2), 3);
        chk("p2_win_over", int'(game_over), 1);
        chk("p2_win_winner", int'(winner), 2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), 1'(i % 3 == 0), 1'b0);
        chk("over_frozen_p2", int'(score_p2), 3);

        // Double miss replays the serve
        do_restart();
        wait_play();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("both_pulse", int'(point_pulse), 0);
        chk("both_hold", int'(ball_hold), 1);
        chk("both_scores", int'(score_p1) + int'(score_p2), 0);
        wait_play();

        // P1 wins 3-1, then restart held high
        do_restart();
        wait_play(); miss(1'b0, 1'b1, 3);
        wait_play(); miss(1'b1, 1'b0, 3);
        wait_play(); miss(1'b0, 1'b1, 3);
        wait_play(); miss(1'b0, 1'b1, 3);
        chk("p1_win_winner", int'(winner), 1);
        chk("p1_win_scores", int'(score_p1) * 16 + int'(score_p2), 3 * 16 + 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("restart_scores", int'(score_p1) + int'(score_p2), 0);
        chk("restart_over", int'(game_over), 0);
        chk("restart_winner", int'(winner), 0);
        chk("restart_dir", int'(serve_dir), 0);
        chk("restart_hold", int'(ball_hold), 1);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-serve at 2/1
        do_restart();
        wait_play(); miss(1'b0, 1'b1, 3);
        wait_play(); miss(1'b0, 1'b1, 3);
        wait_play(); miss(1'b1, 1'b0, 3);
        chk("pre_reset_scores", int'(score_p1) * 16 + int'(score_p2), 2 * 16 + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset_scores", int'(score_p1) + int'(score_p2), 0);
        tick_mode = 0;
        cyc = 0;
        count_serve("post_reset_ticks");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
